// File: rtl/boot_sequencer.sv
// Boot sequencer: drives core reset, boot-address config write, load wait and fetch enable, then monitors the run.
// Latency: every state transition and every output is registered (one cycle from input to output).
// Backpressure: cfg_req_o holds address/data until cfg_gnt_i; load_done_i and cfg_rvalid_i stall the sequence.
module boot_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 12,
    parameter int unsigned POST_RST_CYCLES = 12,
    parameter int unsigned FETCH_DELAY     = 5,
    parameter logic [31:0] CFG_ADDR        = 32'h1A10_7008,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  memload_i,
    input  logic        load_done_i,
    input  logic        eoc_i,
    input  logic [31:0] timeout_i,
    output logic        core_rst_n_o,
    output logic        fetch_enable_o,
    output logic        cfg_req_o,
    output logic [31:0] cfg_addr_o,
    output logic [31:0] cfg_wdata_o,
    input  logic        cfg_gnt_i,
    input  logic        cfg_rvalid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] cycles_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HOLD,
        S_POST_RST,
        S_CFG_REQ,
        S_CFG_RSP,
        S_LOAD_WAIT,
        S_FETCH_DLY,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [1:0] ML_STANDALONE = 2'd2;
    localparam logic [1:0] ML_NOLOAD     = 2'd3;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_EOC     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    localparam logic [31:0] RST_HOLD_W = 32'(RST_HOLD_CYCLES);
    localparam logic [31:0] POST_RST_W = 32'(POST_RST_CYCLES);
    localparam logic [31:0] FETCH_W    = 32'(FETCH_DELAY);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  memload_q, memload_d;
    logic [31:0] timeout_q, timeout_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] cycles_q, cycles_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        fetch_en_q, fetch_en_d;
    logic        cfg_req_q, cfg_req_d;
    logic [31:0] cfg_addr_q, cfg_addr_d;
    logic [31:0] cfg_wdata_q, cfg_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        busy_now;
    logic        cnt_last;
    logic [32:0] cycles_inc;
    logic [31:0] cycles_sat;

    // Next-state, counter and next-output decode; abort outranks every other event while busy.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        memload_d    = memload_q;
        timeout_d    = timeout_q;
        status_d     = status_q;
        cycles_d     = cycles_q;
        core_rst_n_d = 1'b0;
        fetch_en_d   = 1'b0;

        busy_now   = (state_q != S_IDLE) && (state_q != S_DONE);
        // A counter loaded with 0 or 1 both give a one-cycle state.
        cnt_last   = (cnt_q <= 32'd1);
        // 33-bit so a saturated count can never alias a timeout value.
        cycles_inc = {1'b0, cycles_q} + 33'd1;
        cycles_sat = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_inc[31:0];

        if (busy_now && abort_i) begin
            state_d  = S_DONE;
            status_d = ST_ABORT;
            // The abort cycle is still a cycle spent running.
            if (state_q == S_RUN) begin
                cycles_d = cycles_sat;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d   = S_RST_HOLD;
                        memload_d = memload_i;
                        timeout_d = timeout_i;
                        status_d  = ST_NONE;
                        cycles_d  = 32'd0;
                    end
                end
                S_RST_HOLD: begin
                    if (cnt_last) begin
                        state_d = S_POST_RST;
                    end
                end
                S_POST_RST: begin
                    if (cnt_last) begin
                        state_d = (memload_q == ML_STANDALONE) ? S_FETCH_DLY : S_CFG_REQ;
                    end
                end
                S_CFG_REQ: begin
                    if (cfg_gnt_i) begin
                        state_d = S_CFG_RSP;
                    end
                end
                S_CFG_RSP: begin
                    if (cfg_rvalid_i) begin
                        state_d = (memload_q == ML_NOLOAD) ? S_FETCH_DLY : S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (load_done_i) begin
                        state_d = S_FETCH_DLY;
                    end
                end
                S_FETCH_DLY: begin
                    if (cnt_last) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    cycles_d = cycles_sat;
                    if (eoc_i) begin
                        state_d  = S_DONE;
                        status_d = ST_EOC;
                    end else if ((timeout_q != 32'd0) && (cycles_inc == {1'b0, timeout_q})) begin
                        state_d  = S_DONE;
                        status_d = ST_TIMEOUT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Timed states reload their counter on entry and count down while resident.
        if (state_d != state_q) begin
            case (state_d)
                S_RST_HOLD:  cnt_d = RST_HOLD_W;
                S_POST_RST:  cnt_d = POST_RST_W;
                S_FETCH_DLY: cnt_d = FETCH_W;
                default:     cnt_d = 32'd0;
            endcase
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end

        // Core reset / fetch enable follow the state being entered; DONE keeps RUN values unless aborted.
        case (state_d)
            S_POST_RST, S_CFG_REQ, S_CFG_RSP, S_LOAD_WAIT, S_FETCH_DLY: begin
                core_rst_n_d = 1'b1;
                fetch_en_d   = 1'b0;
            end
            S_RUN: begin
                core_rst_n_d = 1'b1;
                fetch_en_d   = 1'b1;
            end
            S_DONE: begin
                if (state_q == S_DONE) begin
                    core_rst_n_d = core_rst_n_q;
                    fetch_en_d   = fetch_en_q;
                end else if (status_d != ST_ABORT) begin
                    core_rst_n_d = 1'b1;
                    fetch_en_d   = 1'b1;
                end
            end
            default: begin
                core_rst_n_d = 1'b0;
                fetch_en_d   = 1'b0;
            end
        endcase

        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        cfg_req_d   = (state_d == S_CFG_REQ);
        cfg_addr_d  = cfg_req_d ? CFG_ADDR  : 32'd0;
        cfg_wdata_d = cfg_req_d ? BOOT_ADDR : 32'd0;
    end

    // State, counters and all registered outputs; synchronous reset drops everything back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 32'd0;
            memload_q    <= 2'd0;
            timeout_q    <= 32'd0;
            status_q     <= ST_NONE;
            cycles_q     <= 32'd0;
            core_rst_n_q <= 1'b0;
            fetch_en_q   <= 1'b0;
            cfg_req_q    <= 1'b0;
            cfg_addr_q   <= 32'd0;
            cfg_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            memload_q    <= memload_d;
            timeout_q    <= timeout_d;
            status_q     <= status_d;
            cycles_q     <= cycles_d;
            core_rst_n_q <= core_rst_n_d;
            fetch_en_q   <= fetch_en_d;
            cfg_req_q    <= cfg_req_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_wdata_q  <= cfg_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign core_rst_n_o   = core_rst_n_q;
    assign fetch_enable_o = fetch_en_q;
    assign cfg_req_o      = cfg_req_q;
    assign cfg_addr_o     = cfg_addr_q;
    assign cfg_wdata_o    = cfg_wdata_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign status_o       = status_q;
    assign cycles_o       = cycles_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: each boot is described by a few timing knobs and the expected
// per-cycle outputs are derived from the phase boundaries of that boot (arithmetic timeline).
// Stimulus: directed boots followed by randomized boots, including aborts, stray inputs and a mid-run reset.
module tb_boot_sequencer;

    localparam int          HOLD  = 12;
    localparam int          POST  = 12;
    localparam int          FDLY  = 5;
    localparam logic [31:0] CADDR = 32'h1A10_7008;
    localparam logic [31:0] BADDR = 32'h0000_0000;

    // Phase lengths: a parameter of 0 still occupies one cycle.
    localparam int H = (HOLD < 1) ? 1 : HOLD;
    localparam int P = (POST < 1) ? 1 : POST;
    localparam int F = (FDLY < 1) ? 1 : FDLY;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, load_done_i, eoc_i, cfg_gnt_i, cfg_rvalid_i;
    logic [1:0]  memload_i;
    logic [31:0] timeout_i;
    logic        core_rst_n_o, fetch_enable_o, cfg_req_o, busy_o, done_o;
    logic [31:0] cfg_addr_o, cfg_wdata_o, cycles_o;
    logic [1:0]  status_o;

    int n_vec = 0;
    int n_err = 0;

    boot_sequencer #(
        .RST_HOLD_CYCLES(HOLD),
        .POST_RST_CYCLES(POST),
        .FETCH_DELAY    (FDLY),
        .CFG_ADDR       (CADDR),
        .BOOT_ADDR      (BADDR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .memload_i     (memload_i),
        .load_done_i   (load_done_i),
        .eoc_i         (eoc_i),
        .timeout_i     (timeout_i),
        .core_rst_n_o  (core_rst_n_o),
        .fetch_enable_o(fetch_enable_o),
        .cfg_req_o     (cfg_req_o),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_wdata_o   (cfg_wdata_o),
        .cfg_gnt_i     (cfg_gnt_i),
        .cfg_rvalid_i  (cfg_rvalid_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .status_o      (status_o),
        .cycles_o      (cycles_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic drive_idle();
        start_i      = 1'b0;
        abort_i      = 1'b0;
        memload_i    = 2'd0;
        load_done_i  = 1'b0;
        eoc_i        = 1'b0;
        timeout_i    = 32'd0;
        cfg_gnt_i    = 1'b0;
        cfg_rvalid_i = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".rstn"},   32'(core_rst_n_o),   32'd0);
        check_val({tag, ".fe"},     32'(fetch_enable_o), 32'd0);
        check_val({tag, ".req"},    32'(cfg_req_o),      32'd0);
        check_val({tag, ".addr"},   cfg_addr_o,          32'd0);
        check_val({tag, ".wdata"},  cfg_wdata_o,         32'd0);
        check_val({tag, ".busy"},   32'(busy_o),         32'd0);
        check_val({tag, ".done"},   32'(done_o),         32'd0);
        check_val({tag, ".status"}, 32'(status_o),       32'd0);
        check_val({tag, ".cycles"}, cycles_o,            32'd0);
    endtask

    // One boot. Cycle 0 carries start_i; cycle c's outputs are sampled 1ns after the edge opening it.
    // gd: cycles of cfg_req before grant; rk: grant-to-rvalid distance (>=1);
    // ld: rvalid-to-load_done distance; e: RUN cycle carrying eoc (0 = never);
    // ab_mode: 0 none, 1 abort in 2nd CFG_REQ cycle, 2 random busy cycle; rst_mode: reset in LOAD_WAIT;
    // sn_mode: stray start pulse while busy.
    task automatic run_boot(input int ml, input logic [31:0] tmo, input int gd, input int rk,
                            input int ld, input int e, input int ab_mode, input bit rst_mode,
                            input bit sn_mode);
        int q_c, g_c, v_c, d_c, r_c, n, st, a_c, end_c, last, ra_c, sn_c, e_cyc;
        bit sa, abd, chk_cyc;
        bit e_busy, e_done, e_req, e_rstn, e_fe;
        int e_st;

        sa  = (ml == 2);
        q_c = H + P + 1;
        g_c = q_c + gd;
        v_c = g_c + rk;
        d_c = 0;
        if (sa)
            r_c = H + P + F + 1;
        else if (ml == 3)
            r_c = v_c + F + 1;
        else begin
            d_c = (ld <= 1) ? v_c + 1 : v_c + ld;
            r_c = d_c + F + 1;
        end
        if (e != 0 && (tmo == 32'd0 || 32'(e) <= tmo)) begin
            n  = e;
            st = 1;
        end else begin
            n  = int'(tmo);
            st = 2;
        end
        a_c = 0;
        if (ab_mode == 1)
            a_c = q_c + 1;
        else if (ab_mode == 2)
            a_c = int'($urandom_range(r_c + n - 1, 1));
        abd = (a_c != 0);
        if (abd) st = 3;
        end_c = abd ? a_c + 1 : r_c + n;
        ra_c  = rst_mode ? v_c + 3 : 0;
        last  = rst_mode ? ra_c + 1 : end_c + 2;
        sn_c  = 0;
        if (sn_mode)
            sn_c = (end_c - 1 >= r_c) ? int'($urandom_range(end_c - 1, r_c))
                                      : int'($urandom_range(end_c - 1, 1));

        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (rst_mode && c == last) begin
                check_reset_outputs("rst_mid");
            end else if (c >= 1) begin
                if (c >= end_c) begin
                    e_busy  = 1'b0;
                    e_done  = 1'b1;
                    e_req   = 1'b0;
                    e_st    = st;
                    e_rstn  = !abd;
                    e_fe    = !abd;
                    chk_cyc = !abd || (a_c < r_c);
                    e_cyc   = abd ? 0 : n;
                end else begin
                    e_busy  = 1'b1;
                    e_done  = 1'b0;
                    e_st    = 0;
                    e_rstn  = (c > H);
                    e_fe    = (c >= r_c);
                    e_req   = !sa && (c >= q_c) && (c <= g_c);
                    chk_cyc = 1'b1;
                    e_cyc   = (c >= r_c) ? c - r_c : 0;
                end
                check_val("busy",   32'(busy_o),         32'(e_busy));
                check_val("done",   32'(done_o),         32'(e_done));
                check_val("rstn",   32'(core_rst_n_o),   32'(e_rstn));
                check_val("fetch",  32'(fetch_enable_o), 32'(e_fe));
                check_val("cfgreq", 32'(cfg_req_o),      32'(e_req));
                check_val("status", 32'(status_o),       32'(e_st));
                if (e_req) begin
                    check_val("cfgaddr",  cfg_addr_o,  CADDR);
                    check_val("cfgwdata", cfg_wdata_o, BADDR);
                end
                if (chk_cyc) check_val("cycles", cycles_o, 32'(e_cyc));
            end

            start_i      = (c == 0) || (sn_c != 0 && c == sn_c);
            abort_i      = (abd && c == a_c) || (!abd && !rst_mode && c == end_c + 1);
            memload_i    = (c == 0) ? 2'(ml) : 2'($urandom);
            timeout_i    = (c == 0) ? tmo : $urandom;
            cfg_gnt_i    = !sa && (c == g_c);
            cfg_rvalid_i = !sa && (c == v_c || c == q_c);
            load_done_i  = !sa && (ml != 3) && (c >= v_c + ld);
            eoc_i        = (c == 2) || (e != 0 && c >= r_c + e - 1);
            rst          = rst_mode && (c == ra_c);
            if (c == last) drive_idle();
        end
    endtask

    initial begin
        int ml, gd, rk, ld, e, ab;
        logic [31:0] tmo;
        bit sn;

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        run_boot(0, 32'd0,  3, 2, 10, 100, 0, 1'b0, 1'b0);  // preload boot, eoc at RUN cycle 100
        run_boot(2, 32'd0,  0, 1, 0,  20,  0, 1'b0, 1'b0);  // standalone: no cfg access
        run_boot(3, 32'd50, 1, 1, 0,  0,   0, 1'b0, 1'b0);  // timeout at 50
        run_boot(1, 32'd50, 2, 3, 4,  50,  0, 1'b0, 1'b0);  // eoc and timeout together
        run_boot(1, 32'd0,  5, 1, 0,  10,  1, 1'b0, 1'b0);  // abort while waiting for grant
        run_boot(0, 32'd0,  1, 1, 2,  30,  0, 1'b0, 1'b1);  // stray start during RUN
        run_boot(0, 32'd40, 0, 1, 2,  10,  0, 1'b0, 1'b0);  // restart from DONE
        run_boot(0, 32'd0,  0, 1, 20, 10,  0, 1'b1, 1'b0);  // reset in LOAD_WAIT
        run_boot(3, 32'd0,  0, 2, 0,  5,   0, 1'b0, 1'b0);  // boot from IDLE after reset

        for (int i = 0; i < 30; i++) begin
            ml  = int'($urandom_range(3, 0));
            tmo = ($urandom_range(2, 0) == 0) ? 32'd0 : 32'($urandom_range(60, 1));
            e   = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(60, 1));
            if (e == 0 && tmo == 32'd0) e = 7;
            gd  = int'($urandom_range(6, 0));
            rk  = int'($urandom_range(4, 1));
            ld  = int'($urandom_range(12, 0));
            ab  = ($urandom_range(3, 0) == 0) ? 2 : 0;
            sn  = ($urandom_range(2, 0) == 0);
            run_boot(ml, tmo, gd, rk, ld, e, ab, 1'b0, sn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 12: cycles core_rst_n_o is held low after start.
REQ-002 Parameter POST_RST_CYCLES, default 12: cycles waited after core reset release, before configuration.
REQ-003 Parameter FETCH_DELAY, default 5: cycles from load complete to fetch_enable_o rising.
REQ-004 Parameter CFG_ADDR, default 32'h1A10_7008: boot-address register address.
REQ-005 Parameter BOOT_ADDR, default 32'h0000_0000: boot address value written.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle pulse; begins a boot sequence.
REQ-009 abort_i  in  1  terminates any active sequence.
REQ-010 memload_i  in  2  0=PRELOAD, 1=SPI, 2=STANDALONE, 3=NOLOAD; sampled with start_i.
REQ-011 load_done_i  in  1  level; external memory load complete.
REQ-012 eoc_i  in  1  end-of-computation flag (GPIO bit 8), synchronous to clk.
REQ-013 timeout_i  in  32  RUN-phase cycle limit; 0 disables timeout; sampled with start_i.
REQ-014 core_rst_n_o  out  1  active-low core reset.
REQ-015 fetch_enable_o  out  1  core fetch enable.
REQ-016 cfg_req_o / cfg_addr_o / cfg_wdata_o  out  1/32/32  configuration write request, address, data.
REQ-017 cfg_gnt_i / cfg_rvalid_i  in  1/1  request accepted / write response.
REQ-018 busy_o  out  1  high in every state except IDLE and DONE.
REQ-019 done_o  out  1  high in DONE.
REQ-020 status_o  out  2  0=none, 1=EOC, 2=TIMEOUT, 3=ABORT.
REQ-021 cycles_o  out  32  RUN-phase cycle count, frozen on entry to DONE.

Function
REQ-022 States: IDLE, RST_HOLD, POST_RST, CFG_REQ, CFG_RSP, LOAD_WAIT, FETCH_DLY, RUN, DONE.
REQ-023 start_i in IDLE or DONE moves to RST_HOLD next cycle and latches memload_i/timeout_i; clears status_o, cycles_o; start_i elsewhere is ignored.
REQ-024 RST_HOLD: core_rst_n_o=0, fetch_enable_o=0 for exactly RST_HOLD_CYCLES cycles, then POST_RST.
REQ-025 POST_RST: core_rst_n_o=1 for POST_RST_CYCLES cycles; then CFG_REQ, or FETCH_DLY if memload=STANDALONE (no cfg access, no load wait).
REQ-026 CFG_REQ: cfg_req_o=1 with cfg_addr_o=CFG_ADDR, cfg_wdata_o=BOOT_ADDR, held stable until the cycle cfg_gnt_i=1; then cfg_req_o=0 and CFG_RSP.
REQ-027 CFG_RSP: wait cfg_rvalid_i=1; then LOAD_WAIT for PRELOAD/SPI, FETCH_DLY for NOLOAD; cfg_rvalid_i outside CFG_RSP ignored.
REQ-028 LOAD_WAIT: wait load_done_i=1 (already-high level qualifies on first cycle); then FETCH_DLY.
REQ-029 FETCH_DLY: FETCH_DELAY cycles, then RUN; fetch_enable_o=1 registered on RUN entry.
REQ-030 RUN: fetch_enable_o=1, cycles_o increments by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-031 RUN exits to DONE: eoc_i=1 -> status 1; else timeout_i!=0 and cycles_o+1==timeout_i -> status 2.
REQ-032 eoc_i and timeout in the same cycle: status 1 (EOC wins).
REQ-033 abort_i while busy_o=1: DONE next cycle, status 3, core_rst_n_o=0, fetch_enable_o=0; abort_i beats eoc_i and timeout; abort_i in IDLE/DONE ignored.
REQ-034 Abort during CFG_REQ drops cfg_req_o next cycle regardless of grant.
REQ-035 DONE after EOC/TIMEOUT: fetch_enable_o and core_rst_n_o keep their RUN values; status_o, cycles_o held until next start_i.
REQ-036 Counters reload on each state entry; a parameter of 0 means the state lasts one cycle.

Reset
REQ-037 rst=1: state IDLE, core_rst_n_o=0, fetch_enable_o=0, cfg_req_o=0, cfg_addr_o=0, cfg_wdata_o=0, busy_o=0, done_o=0, status_o=0, cycles_o=0.
REQ-038 rst mid-sequence overrides all inputs and returns to IDLE next edge, abandoning any cfg transaction.

Verification
REQ-039 PRELOAD boot: start, gnt after 3 cycles, rvalid 2 later, load_done 10 later, eoc after 100 RUN cycles -> core_rst_n_o low 12 cycles, one cfg write 1A10_7008/0, fetch_enable 5 cycles after load_done, status 1, cycles_o=100.
REQ-040 STANDALONE: memload=2 -> cfg_req_o never asserted, fetch_enable_o rises 12+12+5 cycles after RST_HOLD entry.
REQ-041 Timeout: timeout_i=50, eoc_i low -> DONE after 50 RUN cycles, status 2, cycles_o=50; repeat with eoc_i on cycle 50 -> status 1.
REQ-042 Abort in CFG_REQ with gnt low -> cfg_req_o low next cycle, status 3, fetch_enable_o=0, core_rst_n_o=0.
REQ-043 start_i pulsed during RUN ignored; start_i in DONE restarts at RST_HOLD with status_o=0.
REQ-044 rst asserted in LOAD_WAIT -> all outputs at REQ-037 values next cycle.
